// File: rtl/bitrev_pkg.sv
// bitrev_pkg: shared helpers for the bit-reversal scatter buffer
//   bit_reverse(v, k) : reverses the low k bits of v (k <= 32), upper bits zero
//   frame_len(k)      : words per frame, 1 << k
package bitrev_pkg;

    function automatic logic [31:0] bit_reverse(input logic [31:0] v, input int k);
        logic [31:0] r;
        logic [31:0] s;
        r = '0;
        s = v;
        // Shift LSBs of v into r from the right, so v[0] ends up at r[k-1].
        for (int i = 0; i < 32; i++) begin
            if (i < k) begin
                r = {r[30:0], s[0]};
                s = s >> 1;
            end
        end
        return r;
    endfunction

    function automatic int frame_len(input int k);
        return 1 << k;
    endfunction

endpackage

// File: rtl/bitrev_scatter_if.sv
// bitrev_scatter_if: write-side and read-side stream signals of the reorder buffer
//   valid_i/data_i/ready_o : bit-reversed input stream
//   valid_o/data_o/last_o/ready_i : natural-order output stream
interface bitrev_scatter_if #(parameter int DW = 32);

    logic          valid_i;
    logic [DW-1:0] data_i;
    logic          ready_o;
    logic          valid_o;
    logic [DW-1:0] data_o;
    logic          last_o;
    logic          ready_i;

    modport slave  (input valid_i, data_i, ready_i, output ready_o, valid_o, data_o, last_o);
    modport master (output valid_i, data_i, ready_i, input ready_o, valid_o, data_o, last_o);

endinterface

// File: rtl/bitrev_pp_mem.sv
// bitrev_pp_mem: two-bank behavioural memory, one write port and one combinational read port
//   clk_i           : write clock
//   we_i/waddr_i/wdata_i : write port, address MSB selects the bank
//   raddr_i/rdata_o : asynchronous read port
module bitrev_pp_mem #(
    parameter int AW = 11,
    parameter int DW = 32
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk_i) begin
        if (we_i) mem[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/bitrev_scatter.sv
// bitrev_scatter: ping-pong buffer taking bit-reversed frames and emitting natural order
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   s             : stream interface (write side in, read side out, both backpressured)
//   full_o        : per-bank full flags
module bitrev_scatter
    import bitrev_pkg::*;
#(
    parameter int K  = 10,
    parameter int DW = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    bitrev_scatter_if.slave   s,
    output logic [1:0]        full_o
);

    logic [K-1:0]  wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
    logic          wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
    logic [1:0]    full_q, full_d;
    logic          valid_q, valid_d, last_q, last_d;
    logic [DW-1:0] data_q, data_d;
    logic          wr_fire, rd_fire, wr_wrap, rd_wrap;
    logic [K:0]    wr_addr;
    logic [DW-1:0] rd_data;

    always_comb begin
        wr_fire   = s.valid_i && !full_q[wr_bank_q];
        rd_fire   = full_q[rd_bank_q] && (!valid_q || s.ready_i);
        wr_wrap   = wr_fire && (&wr_cnt_q);
        rd_wrap   = rd_fire && (&rd_cnt_q);
        wr_addr   = {wr_bank_q, K'(bit_reverse(32'(wr_cnt_q), K))};
        wr_cnt_d  = wr_fire ? wr_cnt_q + K'(1) : wr_cnt_q;
        rd_cnt_d  = rd_fire ? rd_cnt_q + K'(1) : rd_cnt_q;
        wr_bank_d = wr_bank_q ^ wr_wrap;
        rd_bank_d = rd_bank_q ^ rd_wrap;
        // Writer and reader always touch different banks, so set and clear never collide.
        full_d = full_q;
        if (wr_wrap) full_d[wr_bank_q] = 1'b1;
        if (rd_wrap) full_d[rd_bank_q] = 1'b0;
        // Without rd_fire, a consumed slot can only mean the read bank is empty.
        valid_d = rd_fire ? 1'b1 : (s.ready_i && valid_q) ? 1'b0 : valid_q;
        last_d  = rd_fire ? (&rd_cnt_q) : (s.ready_i && valid_q) ? 1'b0 : last_q;
        data_d  = rd_fire ? rd_data : data_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            full_q    <= 2'b00;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            data_q    <= '0;
        end else begin
            wr_cnt_q  <= wr_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            full_q    <= full_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            data_q    <= data_d;
        end
    end

    bitrev_pp_mem #(.AW(K + 1), .DW(DW)) u_mem (
        .clk_i   (clk_i),
        .we_i    (wr_fire),
        .waddr_i (wr_addr),
        .wdata_i (s.data_i),
        .raddr_i ({rd_bank_q, rd_cnt_q}),
        .rdata_o (rd_data)
    );

    assign s.ready_o = !full_q[wr_bank_q];
    assign s.valid_o = valid_q;
    assign s.data_o  = data_q;
    assign s.last_o  = last_q;
    assign full_o    = full_q;

endmodule
